// File: rtl/dmem_req_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_req_ctrl
//   Takes load/store requests from the EX stage and issues them on the data
//   memory AXI4-Lite AW/W/AR channels. Each valid stays asserted, with its
//   payload frozen, until the matching ready is sampled high. Only one request
//   can be in the issue phase at a time. A counter tracks how many requests
//   have been issued but not yet completed. The MEM stage owns the B/R
//   channels and reports each completion on rsp_done.
//
// Build option
//   DMEM_MISALIGN_CHECK_EN : when defined, misaligned half/word requests are
//                            rejected. The rejection is reported on misalign
//                            and nothing is issued on the bus. When undefined,
//                            misalign is tied low and unaligned requests go
//                            out with shifted data and truncated strobes.
//
// Parameters
//   MAX_OUTST   maximum number of issued-but-uncompleted transactions (1..15)
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   flush           pipeline flush; blocks new accepts this cycle
//   req_valid/ready EX request handshake (accept = valid && ready)
//   req_store       1 = store, 0 = load
//   req_op          funct3; [1:0] selects byte/half/word (11 = word)
//   req_addr        byte address
//   req_wdata       store data, LSB-aligned
//   misalign        same-cycle pulse: request rejected as misaligned
//   axi_aw*/w*/ar*  AXI4-Lite write address, write data and read address
//   rsp_done        one B or R handshake completed this cycle
//   outst_cnt       current outstanding transaction count
// ---------------------------------------------------------------------------
module dmem_req_ctrl #(
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        misalign,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic        rsp_done,
  output logic [3:0]  outst_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg,  wvalid_next;
  logic        arvalid_reg, arvalid_next;
  logic [31:0] awaddr_reg,  awaddr_next;
  logic [31:0] wdata_reg,   wdata_next;
  logic [3:0]  wstrb_reg,   wstrb_next;
  logic [31:0] araddr_reg,  araddr_next;
  logic [3:0]  cnt_reg,     cnt_next;

  logic [1:0]  offs;
  logic        size_half;
  logic        size_word;
  logic [3:0]  strb_base;
  logic [31:0] wdata_lane;
  logic [3:0]  wstrb_lane;
  logic        accept;
  logic        dec_ok;

  // Sign/unsigned selection (funct3[2]) does not matter on the request side.
  logic        unused_op_bit;
  assign unused_op_bit = req_op[2];

  assign offs      = req_addr[1:0];
  assign size_half = (req_op[1:0] == 2'b01);
  // Encoding 11 is treated as a word access.
  assign size_word = req_op[1];

  assign strb_base  = size_word ? 4'b1111 : (size_half ? 4'b0011 : 4'b0001);
  // Both shifts drop bits past the top byte lane. This matters only for
  // unaligned accesses when the alignment check is compiled out.
  assign wstrb_lane = strb_base << offs;
  assign wdata_lane = req_wdata << {offs, 3'b000};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = req_valid && !flush &&
                    ((size_half && offs[0]) || (size_word && (offs != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // A new request is accepted only once every channel of the previous one
  // has handshaked.
  assign req_ready = req_valid && !flush && !awvalid_reg && !wvalid_reg &&
                     !arvalid_reg && (cnt_reg < MAX_CNT) && !misalign;
  assign accept    = req_ready;

  // A completion while nothing is outstanding is spurious and is dropped.
  assign dec_ok = rsp_done && (cnt_reg != 4'd0);

  always_comb begin
    // A valid that is already asserted keeps holding until its own ready,
    // whether or not a flush is in progress.
    awvalid_next = awvalid_reg ? !axi_awready : (accept && req_store);
    wvalid_next  = wvalid_reg  ? !axi_wready  : (accept && req_store);
    arvalid_next = arvalid_reg ? !axi_arready : (accept && !req_store);

    awaddr_next = awaddr_reg;
    wdata_next  = wdata_reg;
    wstrb_next  = wstrb_reg;
    araddr_next = araddr_reg;
    if (accept && req_store) begin
      awaddr_next = req_addr;
      wdata_next  = wdata_lane;
      wstrb_next  = wstrb_lane;
    end
    if (accept && !req_store) begin
      araddr_next = req_addr;
    end

    cnt_next = cnt_reg;
    case ({accept, dec_ok})
      2'b10:   cnt_next = cnt_reg + 4'd1;
      2'b01:   cnt_next = cnt_reg - 4'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      awaddr_reg  <= 32'd0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'd0;
      araddr_reg  <= 32'd0;
      cnt_reg     <= 4'd0;
    end else begin
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      arvalid_reg <= arvalid_next;
      awaddr_reg  <= awaddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      araddr_reg  <= araddr_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign axi_awvalid = awvalid_reg;
  assign axi_wvalid  = wvalid_reg;
  assign axi_arvalid = arvalid_reg;
  assign axi_awaddr  = awaddr_reg;
  assign axi_wdata   = wdata_reg;
  assign axi_wstrb   = wstrb_reg;
  assign axi_araddr  = araddr_reg;
  assign outst_cnt   = cnt_reg;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_req_ctrl
//   Self-checking bench for dmem_req_ctrl. It runs directed scenarios and then
//   a randomized run that is compared against a transaction-level reference
//   model. DMEM_MISALIGN_CHECK_EN selects which alignment behaviour is
//   expected.
// ---------------------------------------------------------------------------
module tb_dmem_req_ctrl;

  localparam int MAX = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        misalign;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready = 1'b0;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready = 1'b0;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic        rsp_done = 1'b0;
  logic [3:0]  outst_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_req_ctrl #(.MAX_OUTST(MAX)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .misalign(misalign),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .rsp_done(rsp_done), .outst_cnt(outst_cnt)
  );

  // One request currently in its issue phase, with the channels still owed.
  typedef struct {
    bit          active;
    bit          aw_left;
    bit          w_left;
    bit          ar_left;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  // Reference arithmetic: store data moves up one byte lane per address offset.
  function automatic logic [31:0] f_wdata(logic [31:0] d, logic [31:0] a);
    longint unsigned v = longint'(d);
    for (int k = 0; k < int'(a % 4); k++) v = v * 256;
    return v[31:0];
  endfunction

  function automatic logic [3:0] f_strb(logic [2:0] op, logic [31:0] a);
    int sz   = int'(op) % 4;
    int base = (sz == 0) ? 1 : ((sz == 1) ? 3 : 15);
    int v    = (base * (1 << int'(a % 4))) % 16;
    return 4'(v);
  endfunction

  function automatic logic f_mis(logic v, logic fl, logic [2:0] op, logic [31:0] a);
    int sz = int'(op) % 4;
    if (!CHK_EN || !v || fl) return 1'b0;
    if (sz == 1) return (a % 2) != 0;
    if (sz >= 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; req_valid = 0; req_store = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    axi_awready = 0; axi_wready = 0; axi_arready = 0; rsp_done = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    @(negedge clk);
    #1;
    checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_valids: got aw=%b w=%b ar=%b want 0", axi_awvalid, axi_wvalid, axi_arvalid); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (axi_awaddr !== 32'd0) begin errors++; $display("FAIL rst_awaddr: got %h want 0", axi_awaddr); end
    checks++; if (axi_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", axi_wdata); end
    checks++; if (axi_wstrb !== 4'd0) begin errors++; $display("FAIL rst_wstrb: got %b want 0", axi_wstrb); end
    checks++; if (axi_araddr !== 32'd0) begin errors++; $display("FAIL rst_araddr: got %h want 0", axi_araddr); end
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", outst_cnt); end
    checks++; if (req_ready !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL rst_ready: got ready=%b mis=%b want 0", req_ready, misalign); end
    $display("txn reset done");
  endtask

  task automatic test_store_word();
    idle();
    req_valid = 1; req_store = 1; req_op = 3'b010; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
    axi_awready = 1; axi_wready = 1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 0;
    #1;
    checks++; if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1) begin errors++; $display("FAIL sw_valids: got aw=%b w=%b want 1", axi_awvalid, axi_wvalid); end
    checks++; if (axi_awaddr !== 32'h100) begin errors++; $display("FAIL sw_awaddr: got %h want 100", axi_awaddr); end
    checks++; if (axi_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb: got %b want 1111", axi_wstrb); end
    checks++; if (axi_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", axi_wdata); end
    checks++; if (outst_cnt !== 4'd1) begin errors++; $display("FAIL sw_cnt: got %0d want 1", outst_cnt); end
    tick();
    #1;
    checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0) begin errors++; $display("FAIL sw_drop: got aw=%b w=%b want 0", axi_awvalid, axi_wvalid); end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    #1;
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL sw_cnt_done: got %0d want 0", outst_cnt); end
    $display("txn SW addr=00000100 data=deadbeef");
  endtask

  task automatic test_store_narrow();
    idle();
    axi_awready = 1; axi_wready = 1;
    req_valid = 1; req_store = 1; req_op = 3'b000; req_addr = 32'h103; req_wdata = 32'h000000AB;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 0;
    #1;
    checks++; if (axi_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", axi_wstrb); end
    checks++; if (axi_wdata !== 32'hAB000000) begin errors++; $display("FAIL sb_wdata: got %h want ab000000", axi_wdata); end
    checks++; if (axi_awaddr !== 32'h103) begin errors++; $display("FAIL sb_awaddr: got %h want 103", axi_awaddr); end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    $display("txn SB addr=00000103 data=000000ab");
    req_valid = 1; req_store = 1; req_op = 3'b001; req_addr = 32'h202; req_wdata = 32'h0000BEEF;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sh_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 0;
    #1;
    checks++; if (axi_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", axi_wstrb); end
    checks++; if (axi_wdata !== 32'hBEEF0000) begin errors++; $display("FAIL sh_wdata: got %h want beef0000", axi_wdata); end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    #1;
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL sh_cnt_done: got %0d want 0", outst_cnt); end
    $display("txn SH addr=00000202 data=0000beef");
  endtask

  task automatic test_load_stall();
    idle();
    req_valid = 1; req_store = 0; req_op = 3'b010; req_addr = 32'h200;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_ready: got %b want 1", req_ready); end
    tick();
    req_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) axi_arready = 1;
      #1;
      checks++; if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h200) begin errors++; $display("FAIL ld_hold%0d: got arvalid=%b araddr=%h want 1/200", i, axi_arvalid, axi_araddr); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ld_busy%0d: got ready=%b want 0", i, req_ready); end
      tick();
    end
    req_valid = 0; axi_arready = 0;
    #1;
    checks++; if (axi_arvalid !== 1'b0 || outst_cnt !== 4'd1) begin errors++; $display("FAIL ld_drop: got arvalid=%b cnt=%0d want 0/1", axi_arvalid, outst_cnt); end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    $display("txn LW addr=00000200 stalled 3 cycles");
  endtask

  task automatic test_max_outst();
    idle();
    axi_arready = 1;
    req_valid = 1; req_store = 0; req_op = 3'b010; req_addr = 32'h10;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mo_first: got %b want 1", req_ready); end
    tick();
    req_addr = 32'h14;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mo_arpend: got %b want 0", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 1'b1 || outst_cnt !== 4'd1) begin errors++; $display("FAIL mo_second: got ready=%b cnt=%0d want 1/1", req_ready, outst_cnt); end
    tick();
    req_addr = 32'h18;
    #1;
    checks++; if (axi_araddr !== 32'h14) begin errors++; $display("FAIL mo_araddr: got %h want 14", axi_araddr); end
    tick();
    #1;
    checks++; if (req_ready !== 1'b0 || outst_cnt !== 4'd2) begin errors++; $display("FAIL mo_full: got ready=%b cnt=%0d want 0/2", req_ready, outst_cnt); end
    rsp_done = 1;
    tick();
    #1;
    checks++; if (req_ready !== 1'b1 || outst_cnt !== 4'd1) begin errors++; $display("FAIL mo_freed: got ready=%b cnt=%0d want 1/1", req_ready, outst_cnt); end
    tick();
    rsp_done = 0; req_valid = 0;
    #1;
    checks++; if (outst_cnt !== 4'd1) begin errors++; $display("FAIL mo_same_cycle: got cnt=%0d want 1", outst_cnt); end
    tick();
    rsp_done = 1;
    tick();
    rsp_done = 0;
    #1;
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL mo_drain: got cnt=%0d want 0", outst_cnt); end
    $display("txn three loads against MAX_OUTST=%0d", MAX);
  endtask

  task automatic test_split_handshake();
    idle();
    axi_awready = 1; axi_wready = 0;
    req_valid = 1; req_store = 1; req_op = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sp_ready: got %b want 1", req_ready); end
    tick();
    #1;
    checks++; if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1) begin errors++; $display("FAIL sp_valids: got aw=%b w=%b want 1/1", axi_awvalid, axi_wvalid); end
    tick();
    axi_awready = 0;
    #1;
    checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL sp_aw_first: got aw=%b w=%b ready=%b want 0/1/0", axi_awvalid, axi_wvalid, req_ready); end
    tick();
    axi_wready = 1;
    #1;
    checks++; if (axi_wvalid !== 1'b1 || axi_wdata !== 32'h12345678 || req_ready !== 1'b0) begin errors++; $display("FAIL sp_w_hold: got w=%b wdata=%h ready=%b want 1/12345678/0", axi_wvalid, axi_wdata, req_ready); end
    tick();
    axi_wready = 0;
    #1;
    checks++; if (axi_wvalid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sp_w_done: got w=%b ready=%b want 0/1", axi_wvalid, req_ready); end
    #1;
    req_valid = 0;
    tick();
    rsp_done = 1;
    tick();
    rsp_done = 0;
    $display("txn SW addr=00000040 split AW/W handshake");
  endtask

  task automatic test_flush_hold();
    idle();
    req_valid = 1; req_store = 0; req_op = 3'b100; req_addr = 32'h80;
    tick();
    flush = 1; req_addr = 32'h84;
    #1;
    checks++; if (req_ready !== 1'b0 || axi_arvalid !== 1'b1) begin errors++; $display("FAIL fl_block: got ready=%b arvalid=%b want 0/1", req_ready, axi_arvalid); end
    tick();
    axi_arready = 1;
    #1;
    checks++; if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h80 || misalign !== 1'b0) begin errors++; $display("FAIL fl_hold: got arvalid=%b araddr=%h mis=%b want 1/80/0", axi_arvalid, axi_araddr, misalign); end
    tick();
    axi_arready = 0; rsp_done = 1;
    #1;
    checks++; if (axi_arvalid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL fl_done: got arvalid=%b ready=%b want 0/0", axi_arvalid, req_ready); end
    tick();
    rsp_done = 0; flush = 0; req_valid = 0;
    #1;
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL fl_cnt: got %0d want 0", outst_cnt); end
    $display("txn LBU addr=00000080 held through flush");
  endtask

  task automatic test_alignment();
    idle();
`ifdef DMEM_MISALIGN_CHECK_EN
    req_valid = 1; req_store = 0; req_op = 3'b010; req_addr = 32'h102;
    #1;
    checks++; if (misalign !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL ma_lw: got mis=%b ready=%b want 1/0", misalign, req_ready); end
    tick();
    req_store = 1; req_op = 3'b001; req_addr = 32'h101;
    #1;
    checks++; if (misalign !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL ma_sh: got mis=%b ready=%b want 1/0", misalign, req_ready); end
    checks++; if (axi_arvalid !== 1'b0 || outst_cnt !== 4'd0) begin errors++; $display("FAIL ma_noissue: got arvalid=%b cnt=%0d want 0/0", axi_arvalid, outst_cnt); end
    tick();
    req_valid = 0;
    #1;
    checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0) begin errors++; $display("FAIL ma_nostore: got aw=%b w=%b want 0/0", axi_awvalid, axi_wvalid); end
    $display("txn misaligned LW/SH rejected");
`else
    axi_awready = 1; axi_wready = 1;
    req_valid = 1; req_store = 1; req_op = 3'b010; req_addr = 32'h102; req_wdata = 32'h11223344;
    #1;
    checks++; if (misalign !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ua_accept: got mis=%b ready=%b want 0/1", misalign, req_ready); end
    tick();
    req_valid = 0;
    #1;
    checks++; if (axi_wstrb !== 4'b1100 || axi_wdata !== 32'h33440000) begin errors++; $display("FAIL ua_lanes: got strb=%b wdata=%h want 1100/33440000", axi_wstrb, axi_wdata); end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    $display("txn unaligned SW addr=00000102 issued");
`endif
  endtask

  task automatic test_underflow();
    idle();
    rsp_done = 1;
    tick();
    tick();
    rsp_done = 0;
    #1;
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL uf_cnt: got %0d want 0", outst_cnt); end
    $display("txn spurious rsp_done at zero");
  endtask

  task automatic test_async_reset();
    idle();
    req_valid = 1; req_store = 1; req_op = 3'b010; req_addr = 32'h55C; req_wdata = 32'hCAFEF00D;
    tick();
    req_valid = 0;
    #1;
    checks++; if (axi_awvalid !== 1'b1) begin errors++; $display("FAIL ar_pre: got awvalid=%b want 1", axi_awvalid); end
    #2;
    reset = 1;
    #1;
    checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || outst_cnt !== 4'd0 || axi_wstrb !== 4'd0) begin errors++; $display("FAIL ar_abort: got aw=%b w=%b cnt=%0d strb=%b want all 0", axi_awvalid, axi_wvalid, outst_cnt, axi_wstrb); end
    @(negedge clk);
    reset = 0;
    $display("txn store aborted by async reset");
  endtask

  task automatic test_random();
    txn_t cur;
    int   m_cnt;
    logic e_mis, e_ready, e_awv, e_wv, e_arv;
    do_reset();
    cur = '{default: 0};
    m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_store   = 1'($urandom_range(0, 1));
      req_op      = 3'($urandom_range(0, 7));
      req_addr    = $urandom;
      req_wdata   = $urandom;
      flush       = ($urandom_range(0, 7) == 0);
      axi_awready = 1'($urandom_range(0, 1));
      axi_wready  = 1'($urandom_range(0, 1));
      axi_arready = 1'($urandom_range(0, 1));
      rsp_done    = ($urandom_range(0, 3) == 0);
      #1;
      e_mis   = f_mis(req_valid, flush, req_op, req_addr);
      e_ready = req_valid && !flush && !cur.active && (m_cnt < MAX) && !e_mis;
      e_awv   = cur.active && cur.aw_left;
      e_wv    = cur.active && cur.w_left;
      e_arv   = cur.active && cur.ar_left;
      checks++; if (misalign !== e_mis) begin errors++; $display("FAIL rnd_mis c%0d: got %b want %b", cyc, misalign, e_mis); end
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, e_ready); end
      checks++; if (axi_awvalid !== e_awv || axi_wvalid !== e_wv || axi_arvalid !== e_arv) begin errors++; $display("FAIL rnd_valids c%0d: got aw=%b w=%b ar=%b want %b/%b/%b", cyc, axi_awvalid, axi_wvalid, axi_arvalid, e_awv, e_wv, e_arv); end
      checks++; if (outst_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, outst_cnt, m_cnt); end
      if (e_awv) begin
        checks++; if (axi_awaddr !== cur.addr) begin errors++; $display("FAIL rnd_awaddr c%0d: got %h want %h", cyc, axi_awaddr, cur.addr); end
      end
      if (e_wv) begin
        checks++; if (axi_wdata !== cur.data || axi_wstrb !== cur.strb) begin errors++; $display("FAIL rnd_w c%0d: got %h/%b want %h/%b", cyc, axi_wdata, axi_wstrb, cur.data, cur.strb); end
      end
      if (e_arv) begin
        checks++; if (axi_araddr !== cur.addr) begin errors++; $display("FAIL rnd_araddr c%0d: got %h want %h", cyc, axi_araddr, cur.addr); end
      end
      @(posedge clk);
      if (cur.aw_left && axi_awready) cur.aw_left = 0;
      if (cur.w_left && axi_wready) cur.w_left = 0;
      if (cur.ar_left && axi_arready) cur.ar_left = 0;
      if (!cur.aw_left && !cur.w_left && !cur.ar_left) cur.active = 0;
      if (e_ready) begin
        cur.active  = 1;
        cur.aw_left = req_store;
        cur.w_left  = req_store;
        cur.ar_left = !req_store;
        cur.addr    = req_addr;
        cur.data    = f_wdata(req_wdata, req_addr);
        cur.strb    = f_strb(req_op, req_addr);
        $display("txn c%0d %s op=%0d addr=%h", cyc, req_store ? "ST" : "LD", req_op, req_addr);
      end
      m_cnt = m_cnt + (e_ready ? 1 : 0) - ((rsp_done && m_cnt > 0) ? 1 : 0);
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_narrow();
    test_load_stall();
    test_max_outst();
    test_split_handshake();
    test_flush_hold();
    test_alignment();
    test_underflow();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
